// File: rtl/mawg_cfg_sequencer_if.sv
// Byte-stream input and register-file write port of the MAWG config sequencer.
// master: the sequencer itself; slave: the UART source / register-file side.
interface mawg_cfg_sequencer_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clear_all;
    logic        frame_err;
    logic        busy;
    logic [7:0]  frame_count;

    modport master (
        input  rx_data, rx_valid,
        output wr_en, wr_addr, wr_data, clear_all, frame_err, busy, frame_count
    );

    modport slave (
        output rx_data, rx_valid,
        input  wr_en, wr_addr, wr_data, clear_all, frame_err, busy, frame_count
    );
endinterface

// File: rtl/mawg_cfg_sequencer.sv
// Assembles UART command frames (cmd + 4 big-endian data bytes) into MAWG config writes.
// Define MAWG_CFG_CHECKSUM_EN to append and verify a 6th XOR checksum byte.
module mawg_cfg_sequencer #(
    parameter int TIMEOUT_CYCLES = 20000
) (
    input  logic                  clk,
    input  logic                  rst,
    mawg_cfg_sequencer_if.master  bus
);

    localparam int TCNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TCNT_W-1:0] TLIM = TCNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, DATA, CHK, COMMIT} state_t;

    state_t            state_q, state_d;
    logic [7:0]        cmd_q, cmd_d;
    logic [31:0]       buf_q, buf_d;
    logic [1:0]        idx_q, idx_d;
    logic [TCNT_W-1:0] tcnt_q, tcnt_d;
    logic [7:0]        fcnt_q, fcnt_d;
    logic              wr_en_q, wr_en_d;
    logic              clear_q, clear_d;
    logic              err_q, err_d;
    logic [3:0]        addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
`ifdef MAWG_CFG_CHECKSUM_EN
    logic [7:0]        chk_q, chk_d;
`endif

    logic commit_go;
    logic expire;

    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign expire = (state_q == DATA || state_q == CHK) && !bus.rx_valid && (tcnt_q == TLIM);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d   = state_q;
        cmd_d     = cmd_q;
        buf_d     = buf_q;
        idx_d     = idx_q;
        fcnt_d    = fcnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wr_en_d   = 1'b0;
        clear_d   = 1'b0;
        err_d     = 1'b0;
        commit_go = 1'b0;
`ifdef MAWG_CFG_CHECKSUM_EN
        chk_d     = chk_q;
`endif

        if (bus.rx_valid || state_q == IDLE || state_q == COMMIT)
            tcnt_d = '0;
        else if (tcnt_q != TLIM)
            tcnt_d = tcnt_q + 1'b1;
        else
            tcnt_d = tcnt_q;

        case (state_q)
            // COMMIT accepts the next cmd byte exactly like IDLE so back-to-back frames lose nothing.
            IDLE, COMMIT: begin
                state_d = IDLE;
                if (bus.rx_valid) begin
                    cmd_d   = bus.rx_data;
                    idx_d   = 2'd0;
                    state_d = DATA;
`ifdef MAWG_CFG_CHECKSUM_EN
                    chk_d   = bus.rx_data;
`endif
                end
            end

            DATA: begin
                if (bus.rx_valid) begin
                    buf_d = {buf_q[23:0], bus.rx_data};
                    idx_d = idx_q + 2'd1;
`ifdef MAWG_CFG_CHECKSUM_EN
                    chk_d = chk_q ^ bus.rx_data;
`endif
                    if (idx_q == 2'd3) begin
`ifdef MAWG_CFG_CHECKSUM_EN
                        state_d   = CHK;
`else
                        state_d   = COMMIT;
                        commit_go = 1'b1;
`endif
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
            end

            CHK: begin
`ifdef MAWG_CFG_CHECKSUM_EN
                if (bus.rx_valid) begin
                    if (bus.rx_data == chk_q) begin
                        state_d   = COMMIT;
                        commit_go = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = IDLE;
                    end
                end else if (expire) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end

            default: state_d = IDLE;
        endcase

        // Strobes are registered here so they appear during the single COMMIT cycle.
        if (commit_go) begin
            if (cmd_q <= 8'h0C) begin
                wr_en_d = 1'b1;
                addr_d  = cmd_q[3:0];
                wdata_d = buf_d;
                fcnt_d  = fcnt_q + 8'd1;
            end else if (cmd_q == 8'h0F) begin
                clear_d = 1'b1;
                fcnt_d  = fcnt_q + 8'd1;
            end else begin
                err_d = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cmd_q   <= '0;
            buf_q   <= '0;
            idx_q   <= '0;
            tcnt_q  <= '0;
            fcnt_q  <= '0;
            wr_en_q <= 1'b0;
            clear_q <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
`ifdef MAWG_CFG_CHECKSUM_EN
            chk_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            cmd_q   <= cmd_d;
            buf_q   <= buf_d;
            idx_q   <= idx_d;
            tcnt_q  <= tcnt_d;
            fcnt_q  <= fcnt_d;
            wr_en_q <= wr_en_d;
            clear_q <= clear_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
`ifdef MAWG_CFG_CHECKSUM_EN
            chk_q   <= chk_d;
`endif
        end
    end

    assign bus.wr_en       = wr_en_q;
    assign bus.wr_addr     = addr_q;
    assign bus.wr_data     = wdata_q;
    assign bus.clear_all   = clear_q;
    assign bus.frame_err   = err_q;
    assign bus.frame_count = fcnt_q;
    assign bus.busy        = (state_q == DATA) || (state_q == CHK);

endmodule

// File: tb/tb_mawg_cfg_sequencer.sv
// Scoreboard bench for mawg_cfg_sequencer: expected strobes are queued as frames are sent
// and matched against the DUT's wr_en / clear_all / frame_err pulses every cycle.
module tb_mawg_cfg_sequencer;

    localparam int T = 40;

    typedef struct {
        logic [2:0]  kind;   // {frame_err, clear_all, wr_en}
        logic [3:0]  addr;
        logic [31:0] data;
        logic [7:0]  fc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mawg_cfg_sequencer_if bus();

    mawg_cfg_sequencer #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int         tests_run = 0;
    int         fails     = 0;
    logic [7:0] fc_model  = 8'h00;
    logic [2:0] prev_obs  = 3'b000;
    exp_t       sb[$];

    task automatic monitor();
        logic [2:0] obs;
        exp_t e;
        obs = {bus.frame_err, bus.clear_all, bus.wr_en};
        if ((obs & prev_obs) != 3'b000) begin
            tests_run++;
            fails++;
            $display("FAIL pulse_width: strobes %b high two cycles in a row", obs & prev_obs);
        end
        prev_obs = obs;
        if (obs != 3'b000) begin
            tests_run++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_strobe: got strobes %b, required none", obs);
            end else begin
                e = sb.pop_front();
                if (obs !== e.kind || bus.frame_count !== e.fc ||
                    (e.kind[0] && (bus.wr_addr !== e.addr || bus.wr_data !== e.data))) begin
                    fails++;
                    $display("FAIL strobe: got kind=%b fc=%h addr=%h data=%h, required kind=%b fc=%h addr=%h data=%h",
                             obs, bus.frame_count, bus.wr_addr, bus.wr_data, e.kind, e.fc, e.addr, e.data);
                end
            end
        end
    endtask

    // Inputs change at the negedge, the DUT samples at the posedge, outputs are read at the next negedge.
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        monitor();
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.rx_data  = b;
        bus.rx_valid = 1'b1;
        tick();
        bus.rx_valid = 1'b0;
    endtask

    task automatic expect_frame(input logic [7:0] cmd, input logic [31:0] data);
        exp_t e;
        e.addr = cmd[3:0];
        e.data = data;
        if (cmd <= 8'h0C) begin
            e.kind = 3'b001;
            fc_model = fc_model + 8'd1;
        end else if (cmd == 8'h0F) begin
            e.kind = 3'b010;
            fc_model = fc_model + 8'd1;
        end else begin
            e.kind = 3'b100;
        end
        e.fc = fc_model;
        sb.push_back(e);
    endtask

    task automatic push_err();
        exp_t e;
        e.kind = 3'b100;
        e.addr = 4'h0;
        e.data = 32'h0;
        e.fc   = fc_model;
        sb.push_back(e);
    endtask

    task automatic send_frame(input logic [7:0] cmd, input logic [31:0] data);
        expect_frame(cmd, data);
        send_byte(cmd);
        for (int i = 3; i >= 0; i--) send_byte(data[i*8 +: 8]);
`ifdef MAWG_CFG_CHECKSUM_EN
        send_byte(cmd ^ data[31:24] ^ data[23:16] ^ data[15:8] ^ data[7:0]);
`endif
    endtask

    task automatic check_idle_zero(input string name);
        tests_run++;
        if ({bus.wr_en, bus.clear_all, bus.frame_err, bus.busy} !== 4'b0000 ||
            bus.wr_addr !== 4'h0 || bus.wr_data !== 32'h0 || bus.frame_count !== 8'h00) begin
            fails++;
            $display("FAIL %s: got wr_en=%b clr=%b err=%b busy=%b addr=%h data=%h fc=%h, required all zero",
                     name, bus.wr_en, bus.clear_all, bus.frame_err, bus.busy,
                     bus.wr_addr, bus.wr_data, bus.frame_count);
        end
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        fc_model = 8'h00;
        check_idle_zero("reset_outputs");
        rst = 1'b1;
    endtask

    task automatic test_reset();
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1'b0;
        do_reset();
    endtask

    task automatic test_write();
        expect_frame(8'h02, 32'h0001_0000);
        send_byte(8'h02);
        tests_run++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL busy_in_frame: got %b, required 1", bus.busy);
        end
        send_byte(8'h00); send_byte(8'h01); send_byte(8'h00); send_byte(8'h00);
`ifdef MAWG_CFG_CHECKSUM_EN
        send_byte(8'h03);
`endif
        tests_run++;
        if (bus.wr_en !== 1'b1 || bus.wr_addr !== 4'h2 || bus.wr_data !== 32'h0001_0000 ||
            bus.frame_count !== 8'h01 || bus.busy !== 1'b0) begin
            fails++;
            $display("FAIL write_latency: got wr_en=%b addr=%h data=%h fc=%h busy=%b, required 1 2 00010000 01 0",
                     bus.wr_en, bus.wr_addr, bus.wr_data, bus.frame_count, bus.busy);
        end
        tick();
        tests_run++;
        if (bus.wr_en !== 1'b0 || bus.wr_addr !== 4'h2 || bus.wr_data !== 32'h0001_0000) begin
            fails++;
            $display("FAIL write_hold: got wr_en=%b addr=%h data=%h, required 0 2 00010000",
                     bus.wr_en, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_clear();
        send_frame(8'h0F, 32'h0000_0000);
        tick();
        tests_run++;
        if (bus.frame_count !== 8'h02 || bus.wr_addr !== 4'h2 || bus.wr_data !== 32'h0001_0000) begin
            fails++;
            $display("FAIL clear_hold: got fc=%h addr=%h data=%h, required 02 2 00010000",
                     bus.frame_count, bus.wr_addr, bus.wr_data);
        end
    endtask

    task automatic test_bad_cmd();
        send_frame(8'h0E, 32'h1122_3344);
        send_frame(8'h0D, 32'hDEAD_BEEF);
        send_frame(8'hA5, 32'h0000_0001);
        send_frame(8'h10, 32'h0000_0002);
        tick();
        tests_run++;
        if (bus.frame_count !== 8'h02 || bus.wr_addr !== 4'h2) begin
            fails++;
            $display("FAIL bad_cmd_count: got fc=%h addr=%h, required 02 2", bus.frame_count, bus.wr_addr);
        end
    endtask

    task automatic test_timeout();
        push_err();
        send_byte(8'h05);
        send_byte(8'hAA);
        for (int i = 0; i < T - 1; i++) tick();
        tests_run++;
        if (bus.busy !== 1'b1) begin
            fails++;
            $display("FAIL timeout_early: got busy=%b, required 1", bus.busy);
        end
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || sb.size() != 0) begin
            fails++;
            $display("FAIL timeout_expiry: got busy=%b pending=%0d, required 0 0", bus.busy, sb.size());
        end
        send_frame(8'h01, 32'h0000_0003);
        tick();
    endtask

    task automatic test_byte_wins();
        expect_frame(8'h05, 32'h0000_0007);
        send_byte(8'h05);
        for (int i = 0; i < T - 1; i++) tick();
        send_byte(8'h00);
        tests_run++;
        if (bus.busy !== 1'b1 || bus.frame_err !== 1'b0) begin
            fails++;
            $display("FAIL byte_wins: got busy=%b err=%b, required 1 0", bus.busy, bus.frame_err);
        end
        send_byte(8'h00); send_byte(8'h00); send_byte(8'h07);
`ifdef MAWG_CFG_CHECKSUM_EN
        send_byte(8'h02);
`endif
        tick();
    endtask

`ifdef MAWG_CFG_CHECKSUM_EN
    task automatic test_checksum();
        logic [7:0] bytes [6];
        bytes = '{8'h09, 8'h00, 8'h00, 8'h80, 8'h00, 8'h89};
        expect_frame(8'h09, 32'h0000_8000);
        foreach (bytes[i]) send_byte(bytes[i]);
        tick();
        push_err();
        bytes[5] = 8'h88;
        foreach (bytes[i]) send_byte(bytes[i]);
        tick();
        tests_run++;
        if (bus.busy !== 1'b0 || bus.wr_addr !== 4'h9 || bus.wr_data !== 32'h0000_8000) begin
            fails++;
            $display("FAIL checksum_bad: got busy=%b addr=%h data=%h, required 0 9 00008000",
                     bus.busy, bus.wr_addr, bus.wr_data);
        end
    endtask
`endif

    task automatic test_back_to_back();
        logic [7:0]  cmd;
        logic [31:0] data;
        do_reset();
        for (int n = 0; n < 256; n++) begin
            cmd  = 8'($urandom_range(0, 12));
            data = $urandom();
            send_frame(cmd, data);
        end
        tick();
        tick();
        tests_run++;
        if (bus.frame_count !== 8'h00 || sb.size() != 0) begin
            fails++;
            $display("FAIL back_to_back_wrap: got fc=%h pending=%0d, required 00 0", bus.frame_count, sb.size());
        end
    endtask

    task automatic test_mid_reset();
        send_frame(8'h07, 32'hCAFE_F00D);
        send_byte(8'h03);
        send_byte(8'h11);
        send_byte(8'h22);
        rst = 1'b0;
        tick();
        fc_model = 8'h00;
        check_idle_zero("mid_frame_reset");
        rst = 1'b1;
        for (int i = 0; i < T + 5; i++) tick();
        send_frame(8'h0C, 32'h1234_5678);
        tick();
        tests_run++;
        if (bus.frame_count !== 8'h01 || bus.wr_addr !== 4'hC || sb.size() != 0) begin
            fails++;
            $display("FAIL after_reset: got fc=%h addr=%h pending=%0d, required 01 c 0",
                     bus.frame_count, bus.wr_addr, sb.size());
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_clear();
        test_bad_cmd();
        test_timeout();
        test_byte_wins();
`ifdef MAWG_CFG_CHECKSUM_EN
        test_checksum();
`endif
        test_back_to_back();
        test_mid_reset();
        tests_run++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: got %0d pending strobes, required 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

endmodule

// File: doc/mawg_cfg_sequencer.md
MAWG_CFG_SEQUENCER -- requirements
Module: mawg_cfg_sequencer

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 20000, giving the inter-byte timeout in clk cycles (20 ms at 1 MHz).
REQ-002 SHALL have port clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  reset.
REQ-004 SHALL have one clock; reset is synchronous and active-low.
REQ-005 SHALL have port rx_data  input  8  received UART byte, valid only when rx_valid=1.
REQ-006 SHALL have port rx_valid  input  1  one-cycle strobe per received byte.
REQ-007 SHALL have port wr_en  output  1  one-cycle write strobe to the MAWG config register file.
REQ-008 SHALL have port wr_addr  output  4  target register index (command code 0x0-0xC).
REQ-009 SHALL have port wr_data  output  32  write payload, big-endian assembled.
REQ-010 SHALL have port clear_all  output  1  one-cycle strobe: zero all MAWG config registers.
REQ-011 SHALL have port frame_err  output  1  one-cycle strobe on any discarded frame.
REQ-012 SHALL have port busy  output  1  high while a frame is partially received.
REQ-013 SHALL have port frame_count  output  8  count of committed frames, wraps 0xFF->0x00.

Function
REQ-014 SHALL use FSM states IDLE, DATA, CHK, COMMIT.
REQ-015 IDLE: on rx_valid SHALL latch rx_data as cmd, clear the byte index to 0, go to DATA.
REQ-016 DATA: each rx_valid SHALL shift the byte into a 32-bit buffer as {buf[23:0], rx_data}; after the 4th byte SHALL go to CHK if checksum is enabled, else to COMMIT.
REQ-017 COMMIT SHALL last exactly one cycle, then go to IDLE; outputs SHALL assert in that cycle, so wr_en follows the final byte's rx_valid by exactly 1 cycle.
REQ-018 In COMMIT, cmd 0x0-0xC: wr_en=1, wr_addr=cmd[3:0], wr_data=buffer, frame_count+1.
REQ-019 In COMMIT, cmd 0xF: clear_all=1, wr_en=0, frame_count+1.
REQ-020 In COMMIT, cmd 0xD, 0xE or 0x10-0xFF: frame_err=1, no write, frame_count unchanged.
REQ-021 wr_addr and wr_data SHALL hold their last values when wr_en=0; wr_en, clear_all and frame_err SHALL never be high for more than one cycle.
REQ-022 busy SHALL be 1 in DATA and CHK and 0 in IDLE and COMMIT.
REQ-023 An rx_valid arriving in COMMIT SHALL be treated as the cmd byte of the next frame (IDLE behaviour), so back-to-back frames lose no bytes.
REQ-024 The timeout counter SHALL clear on every rx_valid and in IDLE; in DATA or CHK, when it reaches TIMEOUT_CYCLES-1 without rx_valid, SHALL pulse frame_err, discard the frame and go to IDLE.
REQ-025 If rx_valid and timeout expiry coincide, the byte SHALL win: it is accepted and no error is raised.
REQ-026 The timeout counter SHALL be wide enough for TIMEOUT_CYCLES and SHALL saturate, never wrap.

Reset
REQ-027 With rst=0 at a clk edge: state=IDLE; cmd, buffer, byte index, timeout counter and frame_count all 0.
REQ-028 During that reset: wr_en=0, clear_all=0, frame_err=0, busy=0, wr_addr=0, wr_data=0.
REQ-029 Reset mid-frame SHALL discard the partial frame silently, with no frame_err.

Configuration
REQ-030 Macro MAWG_CFG_CHECKSUM_EN defined: the frame is 6 bytes; CHK waits for a 6th byte equal to the XOR of bytes 1-5; on match go to COMMIT, on mismatch pulse frame_err the following cycle and go to IDLE.
REQ-031 Macro MAWG_CFG_CHECKSUM_EN undefined: the frame is 5 bytes, CHK is unreachable and no checksum logic is synthesised.

Verification
REQ-032 Send 02 00 01 00 00 (no checksum) -> one cycle after the last strobe, wr_en=1, wr_addr=2, wr_data=0x00010000, frame_count=1.
REQ-033 Send 0F 00 00 00 00 -> clear_all pulses once, wr_en stays 0, frame_count increments.
REQ-034 Send 0E 11 22 33 44 -> frame_err pulses once, no wr_en, frame_count unchanged.
REQ-035 Send 05 AA, then idle for TIMEOUT_CYCLES cycles -> frame_err pulses once, busy falls; a following 01 00 00 00 03 writes addr 1 with data 3.
REQ-036 With MAWG_CFG_CHECKSUM_EN, send 09 00 00 80 00 89 -> write of 0x00008000 to addr 9; the same frame with last byte 88 -> frame_err and no write.
REQ-037 Send 256 valid frames back-to-back with each next cmd byte in the COMMIT cycle -> all writes occur, frame_count wraps to 0x00; asserting rst mid-frame -> all outputs return to 0, no frame_err.
